// File: rtl/ann_io_pkg.sv
// Shared constants and state type for the best-index readout path.
// Geometry of the query grid and the blocked output order live here.
package ann_io_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int ROW_SIZE   = 26;
  localparam int COL_SIZE   = 19;
  localparam int BLOCKING   = 4;
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
  localparam int ADDR_WIDTH = $clog2(NUM_QUERYS);

  localparam int HALF_ROW = ROW_SIZE / 2;
  localparam int NUM_XBLK = (HALF_ROW + BLOCKING - 1) / BLOCKING;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } stream_state_t;

endpackage

// File: rtl/ann_result_fifo2.sv
// Two-entry synchronous FIFO feeding the IO output mux.
// A pop on an empty FIFO is ignored; push and pop in one cycle keep the count.
module ann_result_fifo2 #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wenq,
  input  logic [WIDTH-1:0] wdata,
  input  logic             deq,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty_n,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  always_comb begin
    pop      = deq && (count != 2'd0);
    push     = wenq && ((count != 2'd2) || pop);
    rempty_n = (count != 2'd0);
    rdata    = rd_ptr ? slot1 : slot0;
  end

  // Writes always land in the slot not being presented, so the head stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= wdata;
        else        slot0 <= wdata;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ann_result_streamer.sv
// Walks the best-index memory in blocked order after a start pulse and
// streams one index per word through a small output FIFO to the host.
module ann_result_streamer
  import ann_io_pkg::*;
(
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  send_best_arr,
  output logic                  mem_ren_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] out_fifo_rdata,
  output logic                  out_fifo_rempty_n,
  input  logic                  out_fifo_deq,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW  = $clog2(NUM_QUERYS + ROW_SIZE) + 1;
  localparam int WCW = $clog2(NUM_QUERYS + 1);

  localparam logic [CW-1:0]  C_HALF      = CW'(HALF_ROW);
  localparam logic [CW-1:0]  C_ROW       = CW'(ROW_SIZE);
  localparam logic [CW-1:0]  C_BLK       = CW'(BLOCKING);
  localparam logic [CW-1:0]  C_BLK_LAST  = CW'(BLOCKING - 1);
  localparam logic [CW-1:0]  C_Y_LAST    = CW'(COL_SIZE - 1);
  localparam logic [WCW-1:0] C_LAST_WORD = WCW'(NUM_QUERYS - 1);

  stream_state_t state;
  stream_state_t state_next;

  logic                  px;
  logic [CW-1:0]         xpos;
  logic [CW-1:0]         xi;
  logic [CW-1:0]         y_cnt;
  logic [CW-1:0]         row_base;
  logic [CW-1:0]         col_base;
  logic [WCW-1:0]        word_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  xi_wrap;
  logic                  y_wrap;
  logic                  x_wrap;

  logic       rd_valid;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic       pop;
  logic       credit_ok;
  logic       issue;
  logic       final_pop;

  // A pop this edge frees a slot, so it is credited back before the next issue.
  always_comb begin
    pop        = out_fifo_deq && out_fifo_rempty_n;
    occupancy  = {1'b0, fifo_count} + {2'b00, mem_ren_o} + {2'b00, rd_valid} - {2'b00, pop};
    credit_ok  = (occupancy < 3'd2);
    issue      = 1'b0;
    final_pop  = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (send_best_arr) begin
          issue      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (word_cnt == C_LAST_WORD) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (fifo_count == 2'd1) && !mem_ren_o && !rd_valid) begin
          final_pop  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_addr = ADDR_WIDTH'(col_base + row_base + xi);
    xi_wrap  = (xi == C_BLK_LAST) || ((xpos + xi + CW'(1)) >= C_HALF);
    y_wrap   = (y_cnt == C_Y_LAST);
    x_wrap   = ((xpos + C_BLK) >= C_HALF);
  end

  // Nested px/x/y/xi walk; the final tuple wraps every counter back to word 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      px       <= 1'b0;
      xpos     <= '0;
      xi       <= '0;
      y_cnt    <= '0;
      row_base <= '0;
      col_base <= '0;
      word_cnt <= '0;
    end else if (issue) begin
      word_cnt <= (word_cnt == C_LAST_WORD) ? '0 : word_cnt + WCW'(1);
      if (!xi_wrap) begin
        xi <= xi + CW'(1);
      end else begin
        xi <= '0;
        if (!y_wrap) begin
          y_cnt    <= y_cnt + CW'(1);
          row_base <= row_base + C_ROW;
        end else begin
          y_cnt    <= '0;
          row_base <= '0;
          if (!x_wrap) begin
            xpos     <= xpos + C_BLK;
            col_base <= col_base + C_BLK;
          end else begin
            xpos     <= '0;
            px       <= ~px;
            col_base <= px ? '0 : C_HALF;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      mem_ren_o   <= 1'b0;
      mem_raddr_o <= '0;
      rd_valid    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state     <= state_next;
      mem_ren_o <= issue;
      if (issue) mem_raddr_o <= cur_addr;
      rd_valid  <= mem_ren_o;
      busy_o    <= (state_next != IDLE);
      done_o    <= final_pop;
    end
  end

  ann_result_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .wenq    (rd_valid),
    .wdata   (mem_rdata_i),
    .deq     (out_fifo_deq),
    .rdata   (out_fifo_rdata),
    .rempty_n(out_fifo_rempty_n),
    .count   (fifo_count)
  );

endmodule
